// File: rtl/seg_pkg.sv
// seg_pkg: active-low 7-segment glyph codes ({g,f,e,d,c,b,a}) shared by display logic.
package seg_pkg;
   typedef logic [6:0] glyph_t;
   localparam glyph_t GLYPH_BLANK = 7'h7F;
   localparam glyph_t GLYPH_0 = 7'h40;
   localparam glyph_t GLYPH_1 = 7'h79;
   localparam glyph_t GLYPH_2 = 7'h24;
   localparam glyph_t GLYPH_3 = 7'h30;
   localparam glyph_t GLYPH_4 = 7'h19;
   localparam glyph_t GLYPH_5 = 7'h12;
   localparam glyph_t GLYPH_6 = 7'h02;
   localparam glyph_t GLYPH_7 = 7'h78;
   localparam glyph_t GLYPH_8 = 7'h00;
   localparam glyph_t GLYPH_9 = 7'h10;
   localparam glyph_t GLYPH_A = 7'h08;
   localparam glyph_t GLYPH_B = 7'h03;
   localparam glyph_t GLYPH_C = 7'h46;
   localparam glyph_t GLYPH_D = 7'h21;
   localparam glyph_t GLYPH_E = 7'h06;
   localparam glyph_t GLYPH_F = 7'h0E;
   localparam glyph_t GLYPH_L = 7'h47;
   localparam glyph_t GLYPH_N = 7'h2B;
   localparam glyph_t GLYPH_O = 7'h23;
   localparam glyph_t GLYPH_P = 7'h0C;
   localparam glyph_t GLYPH_R = 7'h2F;
   localparam glyph_t GLYPH_S = 7'h12;
   localparam glyph_t GLYPH_T = 7'h07;
   localparam glyph_t GLYPH_U = 7'h41;
   localparam glyph_t GLYPH_W = 7'h55;
   localparam glyph_t GLYPH_G = 7'h10;
   localparam glyph_t HEX_TAB [16] = '{
      GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
      GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
   };
   function automatic glyph_t hex_to_glyph(logic [3:0] h);
      return HEX_TAB[h];
   endfunction
endpackage

// File: rtl/seg_scroll_driver_if.sv
// seg_scroll_driver_if: valid/ready glyph stream into the display driver.
interface seg_scroll_driver_if;
   import seg_pkg::*;
   glyph_t glyph_i;
   logic   glyph_valid_i;
   logic   glyph_last_i;
   logic   glyph_ready_o;
   modport master (output glyph_i, glyph_valid_i, glyph_last_i, input glyph_ready_o);
   modport slave (input glyph_i, glyph_valid_i, glyph_last_i, output glyph_ready_o);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: one-cycle tick every DIV cycles, counted from reset or the last clr.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick_o
);
   localparam int W = DIV > 1 ? $clog2(DIV) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick_o = !clr && cnt_q == W'(DIV - 1);
      cnt_d = (clr || tick_o) ? '0 : cnt_q + W'(1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/seg_scroll_driver.sv
// seg_scroll_driver: double-buffered glyph message loader driving a scanned,
// static or right-to-left scrolling 4-digit common-anode display.
module seg_scroll_driver
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 65536,
   parameter int SCROLL_DIV  = 100_000_000,
   parameter int MSG_MAX     = 16
) (
   input  logic                clk,
   input  logic                rst,
   seg_scroll_driver_if.slave  glyph_if,
   input  logic                scroll_i,
   output glyph_t              seven_seg_o,
   output logic [3:0]          anode_o,
   output logic                dot_o,
   output logic                wrap_o,
   output logic                overflow_o
);
   localparam int W  = $clog2(MSG_MAX + 3);
   localparam int IW = $clog2(MSG_MAX);
   glyph_t       shadow_q [MSG_MAX];
   glyph_t       shadow_d [MSG_MAX];
   glyph_t       active_q [MSG_MAX];
   glyph_t       active_d [MSG_MAX];
   logic [W-1:0] wr_cnt_q, wr_cnt_d, len_q, len_d, pos_q, pos_d, eff_pos;
   logic [W:0]   idx;
   logic [1:0]   digit_q, digit_d;
   glyph_t       seg_q, seg_d;
   logic [3:0]   an_q, an_d;
   logic         ready_q, ovf_q, ovf_d, wrap_q, wrap_d;
   logic         accept, commit, fits, ref_tick, scr_tick, scr_clr;

   assign accept = glyph_if.glyph_valid_i && ready_q;
   assign commit = accept && glyph_if.glyph_last_i;
   assign fits = wr_cnt_q < W'(MSG_MAX);
   assign scr_clr = commit || !scroll_i;

   tick_gen #(.DIV(REFRESH_DIV)) u_refresh (.clk(clk), .rst(rst), .clr(1'b0), .tick_o(ref_tick));
   tick_gen #(.DIV(SCROLL_DIV)) u_scroll (.clk(clk), .rst(rst), .clr(scr_clr), .tick_o(scr_tick));

   // pos_q idles at 0 in static mode so re-entering scroll mode restarts the pass
   always_comb begin
      shadow_d = shadow_q;
      if (accept && fits) shadow_d[wr_cnt_q[IW-1:0]] = glyph_if.glyph_i;
      active_d = commit ? shadow_d : active_q;
      wr_cnt_d = commit ? '0 : (accept && fits) ? wr_cnt_q + W'(1) : wr_cnt_q;
      len_d = !commit ? len_q : fits ? wr_cnt_q + W'(1) : W'(MSG_MAX);
      ovf_d = ovf_q || (accept && !fits);
      wrap_d = scr_tick && pos_q == len_q + W'(2);
      pos_d = (commit || !scroll_i || wrap_d) ? '0 : scr_tick ? pos_q + W'(1) : pos_q;
      digit_d = digit_q + {1'b0, ref_tick};
      eff_pos = scroll_i ? pos_q : W'(3);
      idx = {1'b0, eff_pos} - {{(W - 1){1'b0}}, digit_q};
      seg_d = (idx[W] || idx[W-1:0] >= len_q) ? GLYPH_BLANK : active_q[idx[IW-1:0]];
      an_d = ~(4'b0001 << digit_q);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shadow_q <= '{default: GLYPH_BLANK};
         active_q <= '{default: GLYPH_BLANK};
         wr_cnt_q <= '0;
         len_q <= '0;
         pos_q <= '0;
         digit_q <= '0;
         seg_q <= GLYPH_BLANK;
         an_q <= 4'b1111;
         ready_q <= 1'b0;
         ovf_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         wr_cnt_q <= wr_cnt_d;
         len_q <= len_d;
         pos_q <= pos_d;
         digit_q <= digit_d;
         seg_q <= seg_d;
         an_q <= an_d;
         ready_q <= 1'b1;
         ovf_q <= ovf_d;
         wrap_q <= wrap_d;
      end

   assign glyph_if.glyph_ready_o = ready_q;
   assign seven_seg_o = seg_q;
   assign anode_o = an_q;
   assign dot_o = 1'b1;
   assign wrap_o = wrap_q;
   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_seg_scroll_driver.sv
// tb_seg_scroll_driver: directed bench; expected digit/segment pairs queue up as
// glyphs are driven and are popped as the scan presents each digit.
module tb_seg_scroll_driver;
   import seg_pkg::*;
   typedef struct { string tag; logic [3:0] an; glyph_t seg; } exp_t;
   logic       clk = 1'b0, rst = 1'b1, scroll_i = 1'b0;
   glyph_t     seven_seg_o;
   logic [3:0] anode_o;
   logic       dot_o, wrap_o, overflow_o;
   int         total = 0, bad = 0, wraps = 0;
   exp_t       sb[$];
   glyph_t     ovf_tab [16] = '{GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
                                GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F, GLYPH_L};

   seg_scroll_driver_if gif ();
   seg_scroll_driver #(.REFRESH_DIV(4), .SCROLL_DIV(32), .MSG_MAX(16)) dut (
      .clk(clk), .rst(rst), .glyph_if(gif), .scroll_i(scroll_i), .seven_seg_o(seven_seg_o),
      .anode_o(anode_o), .dot_o(dot_o), .wrap_o(wrap_o), .overflow_o(overflow_o));

   always #5 clk = ~clk;
   always @(negedge clk) if (wrap_o === 1'b1) wraps++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] an, input glyph_t seg);
      exp_t e;
      e.tag = tag;
      e.an = an;
      e.seg = seg;
      sb.push_back(e);
   endtask

   task automatic send(input glyph_t g, input logic last);
      @(negedge clk);
      gif.glyph_i = g;
      gif.glyph_valid_i = 1'b1;
      gif.glyph_last_i = last;
      @(posedge clk);
      #1;
      gif.glyph_valid_i = 1'b0;
      gif.glyph_last_i = 1'b0;
   endtask

   // skips the commit-edge sample, then waits (bounded) for each queued digit
   task automatic drain();
      exp_t e;
      int n;
      @(posedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n = 0;
         @(negedge clk);
         while (anode_o !== e.an && n < 20) begin
            @(negedge clk);
            n++;
         end
         check({e.tag, "_an"}, 32'(anode_o), 32'(e.an));
         check(e.tag, 32'(seven_seg_o), 32'(e.seg));
      end
   endtask

   initial begin
      int first, second, n, g8, gl, w0;
      logic [3:0] an;
      exp_t e;
      gif.glyph_i = GLYPH_BLANK;
      gif.glyph_valid_i = 1'b0;
      gif.glyph_last_i = 1'b0;
      check("hex_a", 32'(hex_to_glyph(4'hA)), 32'h08);
      check("hex_3", 32'(hex_to_glyph(4'h3)), 32'h30);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_seg", 32'(seven_seg_o), 32'h7F);
      check("rst_an", 32'(anode_o), 32'hF);
      check("rst_ready", 32'(gif.glyph_ready_o), 32'h0);
      check("rst_dot", 32'(dot_o), 32'h1);
      check("rst_ovf", 32'(overflow_o), 32'h0);
      check("rst_wrap", 32'(wrap_o), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         an = ~(4'b0001 << (i / 4));
         push("scan", an, GLYPH_BLANK);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         check({e.tag, "_an"}, 32'(anode_o), 32'(e.an));
         check(e.tag, 32'(seven_seg_o), 32'(e.seg));
      end
      check("ready_up", 32'(gif.glyph_ready_o), 32'h1);

      w0 = wraps;
      send(GLYPH_C, 1'b0);
      send(GLYPH_O, 1'b0);
      send(GLYPH_N, 1'b0);
      send(GLYPH_G, 1'b1);
      push("static_C", 4'b0111, GLYPH_C);
      push("static_o", 4'b1011, GLYPH_O);
      push("static_n", 4'b1101, GLYPH_N);
      push("static_g", 4'b1110, GLYPH_G);
      drain();
      repeat (100) @(negedge clk);
      check("static_nowrap", 32'(wraps - w0), 32'h0);

      scroll_i = 1'b1;
      for (int i = 0; i < 8; i++) send(hex_to_glyph(4'(i + 1)), i == 7);
      push("pos0_s0", 4'b1110, GLYPH_1);
      push("pos0_s1", 4'b1101, GLYPH_BLANK);
      push("pos0_s2", 4'b1011, GLYPH_BLANK);
      push("pos0_s3", 4'b0111, GLYPH_BLANK);
      drain();
      for (int i = 0; i < 8; i++) send(hex_to_glyph(4'(i + 1)), i == 7);
      first = 0;
      second = 0;
      n = 0;
      for (int c = 1; c <= 800; c++) begin
         @(negedge clk);
         if (wrap_o === 1'b1) begin
            n++;
            if (first == 0) first = c;
            else if (second == 0) second = c;
         end
      end
      check("wrap_first", 32'(first), 32'(11 * 32 + 1));
      check("wrap_period", 32'(second - first), 32'(11 * 32));
      check("wrap_count", 32'(n), 32'h2);

      scroll_i = 1'b0;
      send(GLYPH_L, 1'b0);
      send(GLYPH_O, 1'b0);
      send(GLYPH_S, 1'b0);
      send(GLYPH_T, 1'b1);
      push("lost_L", 4'b0111, GLYPH_L);
      push("lost_t", 4'b1110, GLYPH_T);
      drain();
      send(GLYPH_1, 1'b0);
      send(GLYPH_2, 1'b0);
      send(GLYPH_3, 1'b0);
      push("hold_L", 4'b0111, GLYPH_L);
      push("hold_o", 4'b1011, GLYPH_O);
      push("hold_s", 4'b1101, GLYPH_S);
      push("hold_t", 4'b1110, GLYPH_T);
      drain();
      scroll_i = 1'b1;
      repeat (80) @(posedge clk);
      send(GLYPH_4, 1'b1);
      push("new_s0", 4'b1110, GLYPH_1);
      push("new_s1", 4'b1101, GLYPH_BLANK);
      push("new_s2", 4'b1011, GLYPH_BLANK);
      push("new_s3", 4'b0111, GLYPH_BLANK);
      drain();

      for (int i = 0; i < 16; i++) send(ovf_tab[i], 1'b0);
      check("ovf_at_max", 32'(overflow_o), 32'h0);
      send(GLYPH_8, 1'b0);
      check("ovf_set", 32'(overflow_o), 32'h1);
      send(GLYPH_8, 1'b1);
      first = 0;
      g8 = 0;
      gl = 0;
      for (int c = 1; c <= 650; c++) begin
         @(negedge clk);
         if (wrap_o === 1'b1 && first == 0) first = c;
         if (seven_seg_o === GLYPH_8) g8++;
         if (seven_seg_o === GLYPH_L) gl++;
      end
      check("ovf_len16_wrap", 32'(first), 32'(19 * 32 + 1));
      check("ovf_dropped", 32'(g8), 32'h0);
      check("ovf_last_kept", 32'(gl > 0), 32'h1);
      check("ovf_sticky", 32'(overflow_o), 32'h1);

      send(GLYPH_A, 1'b0);
      send(GLYPH_B, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_seg", 32'(seven_seg_o), 32'h7F);
      check("arst_an", 32'(anode_o), 32'hF);
      check("arst_ready", 32'(gif.glyph_ready_o), 32'h0);
      check("arst_ovf", 32'(overflow_o), 32'h0);
      check("arst_wrap", 32'(wrap_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (seven_seg_o !== GLYPH_BLANK) n++;
      end
      check("arst_blank", 32'(n), 32'h0);
      scroll_i = 1'b0;
      send(GLYPH_E, 1'b1);
      push("fresh_E", 4'b0111, GLYPH_E);
      push("fresh_s0", 4'b1110, GLYPH_BLANK);
      drain();
      check("fresh_ovf", 32'(overflow_o), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
